// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed little-endian byte stream, writes it into
// instruction memory, checks a mod-256 checksum and then releases the core.
module imem_boot_loader #(
    parameter int IM_AW   = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boot_req,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             im_we,
    output logic [IM_AW-1:0] im_waddr,
    output logic [31:0]      im_wdata,
    output logic             core_resetb,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IM_AW:0]   word_count
);

    localparam logic [2:0] ST_LEN0 = 3'd0;
    localparam logic [2:0] ST_LEN1 = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [16:0]   N_MAX    = 17'(2 ** IM_AW);

    logic [2:0]       state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [15:0]      n_q, n_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      asm_q, asm_d;
    logic [7:0]       csum_q, csum_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             im_we_q, im_we_d;
    logic [IM_AW-1:0] im_waddr_q, im_waddr_d;
    logic [31:0]      im_wdata_q, im_wdata_d;
    logic             core_resetb_q, core_resetb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [IM_AW:0]   wc_q, wc_d;

    logic             accept_s;
    logic [7:0]       csum_sum_s;
    logic             last_word_s;
    logic             tmo_hit_s;

    // Ready is decoded from state so a byte can be taken every cycle.
    assign rx_ready    = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                         (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign accept_s    = rx_valid && rx_ready;
    assign csum_sum_s  = csum_q + rx_data;
    assign last_word_s = (16'(wc_q) == (n_q - 16'd1));
    assign tmo_hit_s   = (tmo_q == TMO_LAST);

    // Next-state and output decode for the load sequencer.
    always_comb begin
        state_d       = state_q;
        len_lo_d      = len_lo_q;
        n_d           = n_q;
        idx_d         = idx_q;
        asm_d         = asm_q;
        csum_d        = csum_q;
        tmo_d         = tmo_q;
        im_we_d       = 1'b0;
        im_waddr_d    = im_waddr_q;
        im_wdata_d    = im_wdata_q;
        core_resetb_d = core_resetb_q;
        done_d        = done_q;
        error_d       = error_q;
        wc_d          = wc_q;

        case (state_q)
            ST_LEN0: begin
                if (accept_s) begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN1;
                end else begin
                    state_d = ST_LEN0;
                end
            end
            ST_LEN1: begin
                if (accept_s) begin
                    n_d   = {rx_data, len_lo_q};
                    tmo_d = '0;
                    if ((n_d == 16'd0) || ({1'b0, n_d} > N_MAX)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = 2'd0;
                        csum_d  = 8'd0;
                        wc_d    = '0;
                    end
                end else if (tmo_hit_s) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    tmo_d  = '0;
                    csum_d = csum_sum_s;
                    idx_d  = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        2'd3: begin
                            im_we_d    = 1'b1;
                            im_waddr_d = wc_q[IM_AW-1:0];
                            im_wdata_d = {rx_data, asm_q};
                            wc_d       = wc_q + 1'b1;
                            if (last_word_s) begin
                                state_d = ST_CSUM;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                        default: asm_d = asm_q;
                    endcase
                end else if (tmo_hit_s) begin
                    // A partially assembled word is simply abandoned here.
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    tmo_d = '0;
                    if (csum_sum_s == 8'd0) begin
                        state_d       = ST_RUN;
                        done_d        = 1'b1;
                        core_resetb_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RUN: begin
                if (boot_req) begin
                    state_d       = ST_LEN0;
                    core_resetb_d = 1'b0;
                    done_d        = 1'b0;
                    wc_d          = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                if (boot_req) begin
                    state_d = ST_LEN0;
                    error_d = 1'b0;
                    wc_d    = '0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_LEN0;
            end
        endcase

        // The gap counter only lives while a frame is in flight.
        if ((state_d == ST_LEN0) || (state_d == ST_RUN) || (state_d == ST_ERR)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_d;
        end

        busy_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 (state_d == ST_DATA) || (state_d == ST_CSUM);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_LEN0;
            len_lo_q      <= 8'd0;
            n_q           <= 16'd0;
            idx_q         <= 2'd0;
            asm_q         <= 24'd0;
            csum_q        <= 8'd0;
            tmo_q         <= '0;
            im_we_q       <= 1'b0;
            im_waddr_q    <= '0;
            im_wdata_q    <= 32'd0;
            core_resetb_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            wc_q          <= '0;
        end else begin
            state_q       <= state_d;
            len_lo_q      <= len_lo_d;
            n_q           <= n_d;
            idx_q         <= idx_d;
            asm_q         <= asm_d;
            csum_q        <= csum_d;
            tmo_q         <= tmo_d;
            im_we_q       <= im_we_d;
            im_waddr_q    <= im_waddr_d;
            im_wdata_q    <= im_wdata_d;
            core_resetb_q <= core_resetb_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            wc_q          <= wc_d;
        end
    end

    assign im_we       = im_we_q;
    assign im_waddr    = im_waddr_q;
    assign im_wdata    = im_wdata_q;
    assign core_resetb = core_resetb_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign word_count  = wc_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: the driver pushes the writes each
// frame should produce, a monitor pops and compares on every im_we.
module tb_imem_boot_loader;

    localparam int IM_AW   = 10;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             boot_req = 1'b0;
    logic [7:0]       rx_data = 8'd0;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic             im_we;
    logic [IM_AW-1:0] im_waddr;
    logic [31:0]      im_wdata;
    logic             core_resetb;
    logic             busy;
    logic             done;
    logic             error;
    logic [IM_AW:0]   word_count;

    imem_boot_loader #(.IM_AW(IM_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .boot_req(boot_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .core_resetb(core_resetb), .busy(busy), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wv[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (im_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%h expected none", im_waddr, im_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", 32'(im_waddr), e.addr);
                chk("write_data", im_wdata, e.data);
                chk("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one byte (after an optional idle gap) and wait for the handshake.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit breq);
        bit acc;
        acc = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) sync();
        rx_data  = b;
        rx_valid = 1'b1;
        boot_req = breq;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            sync();
        end else begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout actual=no_ready expected=ready");
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        boot_req = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Send a whole frame built from wv[] and check the final status.
    task automatic do_load(input int gap_pos, input int gap_len, input int breq_pos, input bit bad);
        int          n;
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  sum;
        logic [7:0]  cs;
        exp_t        e;
        n   = wv.size();
        sum = 8'd0;
        sync();
        send_byte(n[7:0], 0, 1'b0);
        send_byte(n[15:8], 0, 1'b0);
        for (int i = 0; i < 4 * n; i++) begin
            w = wv[i / 4];
            b = w[8 * (i % 4) +: 8];
            sum = sum + b;
            send_byte(b, (i == gap_pos) ? gap_len : 0, i == breq_pos);
            if (i % 4 == 3) begin
                e.cyc  = cyc;
                e.addr = 32'(i / 4);
                e.data = w;
                exp_q.push_back(e);
            end
        end
        cs = 8'd0 - sum + (bad ? 8'd1 : 8'd0);
        send_byte(cs, 0, 1'b0);
        @(negedge clk);
        chk("load_done", 32'(done), bad ? 32'd0 : 32'd1);
        chk("load_error", 32'(error), bad ? 32'd1 : 32'd0);
        chk("load_core_resetb", 32'(core_resetb), bad ? 32'd0 : 32'd1);
        chk("load_word_count", 32'(word_count), 32'(n));
        chk("load_rx_ready", 32'(rx_ready), 32'd0);
        chk("load_busy", 32'(busy), 32'd0);
        chk("load_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_boot(input bit from_run);
        sync();
        boot_req = 1'b1;
        sync();
        boot_req = 1'b0;
        @(negedge clk);
        chk("boot_core_resetb", 32'(core_resetb), 32'd0);
        chk("boot_busy", 32'(busy), 32'd1);
        chk("boot_word_count", 32'(word_count), 32'd0);
        if (from_run) chk("boot_done_clr", 32'(done), 32'd0);
        else          chk("boot_error_clr", 32'(error), 32'd0);
    endtask

    task automatic fixed_words();
        wv.delete();
        wv.push_back(32'h0000_0013);
        wv.push_back(32'h0000_006F);
    endtask

    task automatic rand_words(input int n);
        wv.delete();
        for (int i = 0; i < n; i++) wv.push_back($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        bit bad;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_core_resetb", 32'(core_resetb), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_im_waddr", 32'(im_waddr), 32'd0);
        chk("rst_im_wdata", im_wdata, 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);

        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("idle_no_error", 32'(error), 32'd0);
        chk("idle_busy", 32'(busy), 32'd1);

        fixed_words();
        do_load(-1, 0, -1, 1'b0);
        pulse_boot(1'b1);
        fixed_words();
        do_load(-1, 0, -1, 1'b1);
        chk("badcsum_still_err", 32'(error), 32'd1);
        pulse_boot(1'b0);

        sync();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        @(negedge clk);
        chk("len0_error", 32'(error), 32'd1);
        chk("len0_rx_ready", 32'(rx_ready), 32'd0);
        pulse_boot(1'b0);

        sync();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h04, 0, 1'b0);
        @(negedge clk);
        chk("len1025_error", 32'(error), 32'd1);
        chk("len1025_busy", 32'(busy), 32'd0);
        pulse_boot(1'b0);

        // 16 idle cycles inside word 1 aborts; 15 do not.
        sync();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        begin
            exp_t e;
            for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 0, 1'b0);
            e.cyc  = cyc;
            e.addr = 32'd0;
            e.data = 32'hA3A2_A1A0;
            exp_q.push_back(e);
        end
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("gap15_no_error", 32'(error), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("gap16_error", 32'(error), 32'd1);
        chk("gap16_word_count", 32'(word_count), 32'd1);
        chk("gap16_queue", 32'(exp_q.size()), 32'd0);
        pulse_boot(1'b0);

        fixed_words();
        do_load(5, 10, -1, 1'b0);
        pulse_boot(1'b1);
        rand_words(3);
        do_load(-1, 0, 6, 1'b0);
        pulse_boot(1'b1);

        for (int r = 0; r < 8; r++) begin
            n   = int'($urandom_range(1, 6));
            bad = ($urandom_range(0, 3) == 0);
            rand_words(n);
            do_load(int'($urandom_range(0, 4 * n - 1)), int'($urandom_range(0, 15)), -1, bad);
            pulse_boot(!bad);
        end

        sync();
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        send_byte(8'h66, 0, 1'b0);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
        chk("midrst_im_we", 32'(im_we), 32'd0);
        chk("midrst_core_resetb", 32'(core_resetb), 32'd0);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        rand_words(2);
        do_load(-1, 0, -1, 1'b0);
        pulse_boot(1'b1);

        rand_words(1024);
        do_load(-1, 0, -1, 1'b0);

        repeat (3) @(posedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
